// File: rtl/io_in_buffer_pkg.sv
// Shared defaults and helpers for the processor input-port buffer.
// Sample width, channel count and FIFO depth live here so they stay common with the processor top.
package io_in_buffer_pkg;

  localparam int unsigned NBITS_DEF  = 16;
  localparam int unsigned NUIOIN_DEF = 4;
  localparam int unsigned DEPTH_DEF  = 8;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lsb_index(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (onehot[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_fifo_ch.sv
// Single-channel synchronous FIFO with async reset.
// The head entry is visible combinationally so a read can complete in the strobe cycle.
module io_fifo_ch #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [NBITS-1:0]           wr_data,
  output logic [NBITS-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [NBITS-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/io_in_buffer.sv
// Per-address input FIFOs feeding the processor's input port.
// The read strobe pops the addressed channel and the sample appears on io_in in the same cycle.
module io_in_buffer
  import io_in_buffer_pkg::*;
#(
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NBITS  = NBITS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned CW    = $clog2(NUIOIN),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [CW-1:0]     wr_chan,
  input  logic [NBITS-1:0]  wr_data,
  output logic              wr_ready,
  input  logic [NUIOIN-1:0] req_in,
  output logic [NBITS-1:0]  io_in,
  output logic [NUIOIN-1:0] empty,
  output logic [NUIOIN-1:0] full,
  output logic [NUIOIN-1:0] underflow,
  output logic [NUIOIN-1:0] overflow
);

  logic [NUIOIN-1:0] ch_push;
  logic [NUIOIN-1:0] ch_pop;
  logic [NUIOIN-1:0] ch_empty;
  logic [NUIOIN-1:0] ch_full;
  logic [NBITS-1:0]  ch_head  [NUIOIN];
  logic [AW:0]       ch_count [NUIOIN];
  logic [NBITS-1:0]  hold     [NUIOIN];

  logic              chan_ok;
  logic              rd_any;
  logic [CW-1:0]     rd_idx;

  // Write side never looks at req_in so the producer handshake stays independent of reads.
  assign chan_ok  = {1'b0, wr_chan} < (CW+1)'(NUIOIN);
  assign wr_ready = chan_ok && !ch_full[wr_chan];

  assign rd_any = |req_in;
  assign rd_idx = CW'(lsb_index(32'(req_in)));

  for (genvar i = 0; i < NUIOIN; i++) begin : g_ch
    assign ch_push[i] = wr_valid && wr_ready && (wr_chan == CW'(i));
    assign ch_pop[i]  = rd_any && (rd_idx == CW'(i)) && (ch_count[i] != '0);

    io_fifo_ch #(
      .NBITS (NBITS),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (ch_push[i]),
      .pop     (ch_pop[i]),
      .wr_data (wr_data),
      .head    (ch_head[i]),
      .count   (ch_count[i]),
      .empty   (ch_empty[i]),
      .full    (ch_full[i])
    );
  end

  // An empty channel replays its last delivered sample; an idle strobe shows channel 0.
  always_comb begin
    io_in = hold[0];
    if (rd_any) begin
      io_in = ch_empty[rd_idx] ? hold[rd_idx] : ch_head[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= '0;
      overflow  <= '0;
      for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
    end else begin
      if (rd_any && ch_empty[rd_idx])          underflow[rd_idx] <= 1'b1;
      if (wr_valid && chan_ok && ch_full[wr_chan]) overflow[wr_chan] <= 1'b1;
      for (int i = 0; i < NUIOIN; i++) begin
        if (ch_pop[i]) hold[i] <= ch_head[i];
      end
    end
  end

  assign empty = ch_empty;
  assign full  = ch_full;

endmodule

// File: tb/tb_io_in_buffer.sv
// Directed bench for io_in_buffer with a per-channel queue scoreboard.
module tb_io_in_buffer;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [1:0]  wr_chan;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  req_in;
  logic [15:0] io_in;
  logic [3:0]  empty;
  logic [3:0]  full;
  logic [3:0]  underflow;
  logic [3:0]  overflow;

  int tests = 0;
  int fails = 0;

  logic [15:0] sbq [4][$];
  logic [15:0] mhold [4];
  logic [3:0]  exp_under;
  logic [3:0]  exp_over;

  io_in_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_chan   (wr_chan),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .req_in    (req_in),
    .io_in     (io_in),
    .empty     (empty),
    .full      (full),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: checks handshake and read data before the edge, flags after it.
  task automatic cycle(input logic wv, input logic [1:0] wc, input logic [15:0] wd,
                       input logic [3:0] req);
    logic        exp_ready;
    logic [15:0] exp_io;
    logic        do_pop;
    logic [3:0]  exp_empty;
    logic [3:0]  exp_full;
    int          k;
    wr_valid = wv;
    wr_chan  = wc;
    wr_data  = wd;
    req_in   = req;
    #3;
    exp_ready = (sbq[wc].size() < 8);
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    do_pop = 1'b0;
    k      = 0;
    exp_io = mhold[0];
    if (req != 4'b0000) begin
      for (int i = 3; i >= 0; i--) if (req[i]) k = i;
      if (sbq[k].size() > 0) begin
        exp_io = sbq[k][0];
        do_pop = 1'b1;
      end else begin
        exp_io       = mhold[k];
        exp_under[k] = 1'b1;
      end
    end
    check("io_in", 32'(io_in), 32'(exp_io));
    @(posedge clk);
    #1;
    if (do_pop) mhold[k] = sbq[k].pop_front();
    if (wv) begin
      if (exp_ready) sbq[wc].push_back(wd);
      else           exp_over[wc] = 1'b1;
    end
    wr_valid = 1'b0;
    req_in   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp_empty[i] = (sbq[i].size() == 0);
      exp_full[i]  = (sbq[i].size() == 8);
    end
    check("empty", 32'(empty), 32'(exp_empty));
    check("full", 32'(full), 32'(exp_full));
    check("underflow", 32'(underflow), 32'(exp_under));
    check("overflow", 32'(overflow), 32'(exp_over));
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_chan   = 2'd0;
    wr_data   = 16'h0000;
    req_in    = 4'b0000;
    exp_under = 4'b0000;
    exp_over  = 4'b0000;
    for (int i = 0; i < 4; i++) mhold[i] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;

    // Reset state and idle handshake on every channel.
    check("rst_io_in", 32'(io_in), 32'h0);
    check("rst_empty", 32'(empty), 32'hF);
    for (int c = 0; c < 4; c++) cycle(1'b0, 2'(c), 16'h0000, 4'b0000);

    // Channel 2 in-order delivery, then underflow replays the last value.
    cycle(1'b1, 2'd2, 16'h0011, 4'b0000);
    cycle(1'b1, 2'd2, 16'h0022, 4'b0000);
    cycle(1'b1, 2'd2, 16'h0033, 4'b0000);
    repeat (4) cycle(1'b0, 2'd0, 16'h0000, 4'b0100);

    // Channel 1 fill, overflow, ordered drain.
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'd1, 16'h0100 + 16'(i), 4'b0000);
    cycle(1'b1, 2'd1, 16'h01FF, 4'b0000);
    repeat (8) cycle(1'b0, 2'd0, 16'h0000, 4'b0010);

    // Full channel refuses a push even while popping in the same cycle.
    for (int i = 0; i < 8; i++) cycle(1'b1, 2'd1, 16'h0200 + 16'(i), 4'b0000);
    cycle(1'b1, 2'd1, 16'h02FF, 4'b0010);
    repeat (7) cycle(1'b0, 2'd0, 16'h0000, 4'b0010);

    // Multi-bit strobe pops only the lowest channel.
    cycle(1'b1, 2'd0, 16'h00A0, 4'b0000);
    cycle(1'b1, 2'd3, 16'h00B0, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b1001);

    // Same-channel push+pop: non-empty keeps count, empty has no bypass.
    cycle(1'b1, 2'd3, 16'h7FFF, 4'b1000);
    cycle(1'b1, 2'd2, 16'h8000, 4'b0100);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0100);
    cycle(1'b0, 2'd0, 16'h0000, 4'b1000);

    // Pointer wrap on channel 0 with back-to-back push/pop.
    cycle(1'b1, 2'd0, 16'd1, 4'b0000);
    for (int v = 2; v <= 20; v++) cycle(1'b1, 2'd0, 16'(v), 4'b0001);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0001);

    // Asynchronous reset mid-transfer discards everything.
    cycle(1'b1, 2'd0, 16'h0055, 4'b0000);
    cycle(1'b1, 2'd0, 16'h0066, 4'b0000);
    req_in = 4'b0001;
    #3;
    check("pre_rst_io_in", 32'(io_in), 32'h0055);
    rst = 1'b1;
    #1;
    check("async_rst_io_in", 32'(io_in), 32'h0);
    check("async_rst_empty", 32'(empty), 32'hF);
    check("async_rst_full", 32'(full), 32'h0);
    check("async_rst_underflow", 32'(underflow), 32'h0);
    check("async_rst_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      sbq[i].delete();
      mhold[i] = 16'h0000;
    end
    exp_under = 4'b0000;
    exp_over  = 4'b0000;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    req_in = 4'b0000;
    #2;
    cycle(1'b1, 2'd0, 16'h0077, 4'b0000);
    cycle(1'b0, 2'd0, 16'h0000, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
